wb_regfile: RTL and testbench

Writeback stage and architectural register file for the 8-bit pipelined RISC CPU. Sits directly downstream of the data-memory/writeback pipeline register. It consumes the registered opcode, destination register index, ALU result and memory load data, and commits the selected result into one of four 8-bit general registers. It serves two combinational read ports, with same-cycle write bypass, to the decode stage. It also maintains a zero flag, a halt latch and a retired-instruction counter.

---
 rtl/wb_regfile.sv | 135 +++++++++++++
 tb/tb_wb_regfile.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Writeback stage and architectural register file of the 8-bit
//            pipelined RISC CPU. Commits ALU or load results into four 8-bit
//            general registers. Serves two combinational read ports with
//            same-cycle write bypass. Keeps a zero flag, a halt latch and a
//            saturating retired-instruction counter.
// Ports    : clk, rst_n (sync, active low)
//            wb_valid, wb_op[3:0], wb_ra[1:0], wb_alu_data[7:0],
//            wb_mem_data[7:0]                       - writeback inputs
//            rd_addr_a/b[1:0] -> rd_data_a/b[7:0]   - combinational reads
//            wr_en, wr_addr[1:0], wr_data[7:0]      - commit (combinational)
//            zero_flag, halted, retired[15:0]       - registered status
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [3:0]  wb_op,
  input  logic [1:0]  wb_ra,
  input  logic [7:0]  wb_alu_data,
  input  logic [7:0]  wb_mem_data,
  input  logic [1:0]  rd_addr_a,
  input  logic [1:0]  rd_addr_b,
  output logic [7:0]  rd_data_a,
  output logic [7:0]  rd_data_b,
  output logic        wr_en,
  output logic [1:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        zero_flag,
  output logic        halted,
  output logic [15:0] retired
);

  localparam logic [3:0]  C_OP_NOP      = 4'h0;
  localparam logic [3:0]  C_OP_LOAD     = 4'h8;
  localparam logic [3:0]  C_OP_HALT     = 4'hF;
  localparam logic [15:0] C_RETIRED_MAX = 16'hFFFF;

  // Architectural state
  logic [7:0]  regs_q [4];
  logic [7:0]  regs_d [4];
  logic        zero_q;
  logic        zero_d;
  logic        halted_q;
  logic        halted_d;
  logic [15:0] retired_q;
  logic [15:0] retired_d;

  // Decode
  logic live;
  logic op_writes;
  logic op_halt;

  always_comb begin
    // Once halted, nothing further is accepted until reset.
    live      = wb_valid && !halted_q;
    // Opcodes 1..8 (ALU group plus LOAD) are the only register writers.
    op_writes = (wb_op != C_OP_NOP) && (wb_op <= C_OP_LOAD);
    op_halt   = (wb_op == C_OP_HALT);
  end

  // Commit port. wr_data is driven regardless of wr_en so downstream
  // forwarding logic can observe it without extra gating.
  always_comb begin
    wr_en   = live && op_writes;
    wr_addr = wb_ra;
    wr_data = (wb_op == C_OP_LOAD) ? wb_mem_data : wb_alu_data;
  end

  // Read ports with write-through bypass so decode sees the value being
  // committed this cycle without a one-cycle hazard.
  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    if (wr_en && (rd_addr_a == wb_ra)) begin
      rd_data_a = wr_data;
    end
    if (wr_en && (rd_addr_b == wb_ra)) begin
      rd_data_b = wr_data;
    end
  end

  // Next-state computation
  always_comb begin
    regs_d    = regs_q;
    zero_d    = zero_q;
    halted_d  = halted_q;
    retired_d = retired_q;

    if (wr_en) begin
      regs_d[wb_ra] = wr_data;
      zero_d        = (wr_data == 8'h00);
    end

    if (live && op_halt) begin
      halted_d = 1'b1;
    end

    // Every live instruction retires, NOPs and HALT included; the count
    // sticks at all-ones rather than wrapping.
    if (live && (retired_q != C_RETIRED_MAX)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  // State registers. Reset takes priority over any in-flight writeback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'h00;
      end
      zero_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      zero_q    <= zero_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    zero_flag = zero_q;
    halted    = halted_q;
    retired   = retired_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Self-checking bench for wb_regfile. Directed scenarios plus a
//            randomized run compared against a behavioural register-file
//            model kept in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [3:0]  wb_op;
  logic [1:0]  wb_ra;
  logic [7:0]  wb_alu_data;
  logic [7:0]  wb_mem_data;
  logic [1:0]  rd_addr_a;
  logic [1:0]  rd_addr_b;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        zero_flag;
  logic        halted;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural state
  logic [7:0] m_r [4];
  logic       m_z;
  logic       m_h;
  int         m_cnt;

  wb_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_valid    (wb_valid),
    .wb_op       (wb_op),
    .wb_ra       (wb_ra),
    .wb_alu_data (wb_alu_data),
    .wb_mem_data (wb_mem_data),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .zero_flag   (zero_flag),
    .halted      (halted),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- model helpers (expectations from the opcode rules) ----
  function automatic logic exp_wr_en();
    return wb_valid && !m_h && (wb_op >= 4'h1) && (wb_op <= 4'h8);
  endfunction

  function automatic logic [7:0] exp_wr_data();
    return (wb_op == 4'h8) ? wb_mem_data : wb_alu_data;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [1:0] addr);
    if (exp_wr_en() && addr == wb_ra) return exp_wr_data();
    return m_r[addr];
  endfunction

  function automatic logic [15:0] exp_retired();
    return (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0];
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] ra,
                       input logic [7:0] alu, input logic [7:0] mem);
    wb_valid    = v;
    wb_op       = op;
    wb_ra       = ra;
    wb_alu_data = alu;
    wb_mem_data = mem;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 2'd0, 8'h00, 8'h00);
  endtask

  // Advance one clock; the model absorbs the instruction presented now.
  task automatic tick();
    logic [7:0] n_r [4];
    logic       n_z;
    logic       n_h;
    int         n_cnt;
    logic       live;
    n_r   = m_r;
    n_z   = m_z;
    n_h   = m_h;
    n_cnt = m_cnt;
    live  = wb_valid && !m_h;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) n_r[i] = 8'h00;
      n_z   = 1'b0;
      n_h   = 1'b0;
      n_cnt = 0;
    end else begin
      if (exp_wr_en()) begin
        n_r[wb_ra] = exp_wr_data();
        n_z        = (exp_wr_data() == 8'h00);
      end
      if (live && wb_op == 4'hF) n_h = 1'b1;
      if (live) n_cnt = n_cnt + 1;
    end
    @(posedge clk);
    #1;
    m_r   = n_r;
    m_z   = n_z;
    m_h   = n_h;
    m_cnt = n_cnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    drive(1'b1, 4'h1, 2'd1, 8'hAB, 8'hCD);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 4; i++) begin
      rd_addr_a = 2'(i);
      rd_addr_b = 2'(3 - i);
      #1;
      checks++;
      if (rd_data_a !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg_a[%0d] got %h exp 00", i, rd_data_a);
      end
      checks++;
      if (rd_data_b !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg_b[%0d] got %h exp 00", 3 - i, rd_data_b);
      end
    end
    checks++;
    if (zero_flag !== 1'b0 || halted !== 1'b0 || retired !== 16'h0000) begin
      errors++;
      $display("FAIL reset_status got z=%b h=%b r=%h exp z=0 h=0 r=0000", zero_flag, halted, retired);
    end
  endtask

  task automatic test_alu_write();
    do_reset();
    rd_addr_a = 2'd2;
    rd_addr_b = 2'd0;
    drive(1'b1, 4'h1, 2'd2, 8'h5A, 8'h99);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 2'd2 || wr_data !== 8'h5A) begin
      errors++;
      $display("FAIL alu_commit got en=%b a=%0d d=%h exp en=1 a=2 d=5a", wr_en, wr_addr, wr_data);
    end
    checks++;
    if (rd_data_a !== 8'h5A || rd_data_b !== 8'h00) begin
      errors++;
      $display("FAIL alu_bypass got a=%h b=%h exp a=5a b=00", rd_data_a, rd_data_b);
    end
    tick();
    idle();
    checks++;
    if (rd_data_a !== 8'h5A) begin
      errors++;
      $display("FAIL alu_after_edge got %h exp 5a", rd_data_a);
    end
    checks++;
    if (zero_flag !== 1'b0 || retired !== 16'd1) begin
      errors++;
      $display("FAIL alu_status got z=%b r=%0d exp z=0 r=1", zero_flag, retired);
    end
  endtask

  task automatic test_load_store();
    rd_addr_a = 2'd1;
    rd_addr_b = 2'd2;
    drive(1'b1, 4'h8, 2'd1, 8'hFF, 8'h00);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 8'h00 || rd_data_a !== 8'h00) begin
      errors++;
      $display("FAIL load_commit got en=%b d=%h a=%h exp en=1 d=00 a=00", wr_en, wr_data, rd_data_a);
    end
    tick();
    drive(1'b1, 4'h9, 2'd1, 8'h42, 8'h24);
    checks++;
    if (wr_en !== 1'b0 || wr_data !== 8'h42 || rd_data_a !== 8'h00) begin
      errors++;
      $display("FAIL store_no_write got en=%b d=%h a=%h exp en=0 d=42 a=00", wr_en, wr_data, rd_data_a);
    end
    checks++;
    if (zero_flag !== 1'b1 || retired !== 16'd2) begin
      errors++;
      $display("FAIL load_status got z=%b r=%0d exp z=1 r=2", zero_flag, retired);
    end
    tick();
    idle();
    checks++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h5A || zero_flag !== 1'b1 || retired !== 16'd3) begin
      errors++;
      $display("FAIL store_status got r1=%h r2=%h z=%b r=%0d exp r1=00 r2=5a z=1 r=3",
               rd_data_a, rd_data_b, zero_flag, retired);
    end
  endtask

  task automatic test_bubble();
    rd_addr_a = 2'd0;
    drive(1'b0, 4'h1, 2'd0, 8'h33, 8'h00);
    checks++;
    if (wr_en !== 1'b0 || rd_data_a !== 8'h00) begin
      errors++;
      $display("FAIL bubble_comb got en=%b a=%h exp en=0 a=00", wr_en, rd_data_a);
    end
    tick();
    checks++;
    if (rd_data_a !== 8'h00 || retired !== 16'd3) begin
      errors++;
      $display("FAIL bubble_after got r0=%h r=%0d exp r0=00 r=3", rd_data_a, retired);
    end
  endtask

  task automatic test_halt();
    do_reset();
    rd_addr_a = 2'd3;
    drive(1'b1, 4'hF, 2'd3, 8'h12, 8'h34);
    tick();
    drive(1'b1, 4'h1, 2'd3, 8'h77, 8'h00);
    checks++;
    if (halted !== 1'b1 || wr_en !== 1'b0 || rd_data_a !== 8'h00) begin
      errors++;
      $display("FAIL halt_block got h=%b en=%b r3=%h exp h=1 en=0 r3=00", halted, wr_en, rd_data_a);
    end
    tick();
    idle();
    checks++;
    if (rd_data_a !== 8'h00 || retired !== 16'd1 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_after got r3=%h r=%0d h=%b exp r3=00 r=1 h=1", rd_data_a, retired, halted);
    end
  endtask

  task automatic test_reset_override();
    do_reset();
    drive(1'b1, 4'h2, 2'd2, 8'h44, 8'h00);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 4'h1, 2'd0, 8'h11, 8'h00);
    tick();
    rst_n = 1'b1;
    idle();
    rd_addr_a = 2'd0;
    rd_addr_b = 2'd2;
    #1;
    checks++;
    if (rd_data_a !== 8'h00 || rd_data_b !== 8'h00 || retired !== 16'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_over_write got r0=%h r2=%h r=%0d h=%b exp 00 00 0 0",
               rd_data_a, rd_data_b, retired, halted);
    end
    drive(1'b1, 4'hF, 2'd0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 2'd0, 8'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    idle();
    checks++;
    if (halted !== 1'b0 || retired !== 16'd0) begin
      errors++;
      $display("FAIL rst_over_halt got h=%b r=%0d exp h=0 r=0", halted, retired);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      op    = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h8;
      rd_addr_a = 2'($urandom_range(0, 3));
      rd_addr_b = 2'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 3) != 0), op, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
            ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
      checks++;
      if (wr_en !== exp_wr_en() || wr_addr !== wb_ra || wr_data !== exp_wr_data()) begin
        errors++;
        $display("FAIL rand_commit[%0d] got en=%b a=%0d d=%h exp en=%b a=%0d d=%h",
                 n, wr_en, wr_addr, wr_data, exp_wr_en(), wb_ra, exp_wr_data());
      end
      checks++;
      if (rd_data_a !== exp_rd(rd_addr_a) || rd_data_b !== exp_rd(rd_addr_b)) begin
        errors++;
        $display("FAIL rand_read[%0d] got a=%h b=%h exp a=%h b=%h",
                 n, rd_data_a, rd_data_b, exp_rd(rd_addr_a), exp_rd(rd_addr_b));
      end
      tick();
      checks++;
      if (zero_flag !== m_z || halted !== m_h || retired !== exp_retired()) begin
        errors++;
        $display("FAIL rand_status[%0d] got z=%b h=%b r=%h exp z=%b h=%b r=%h",
                 n, zero_flag, halted, retired, m_z, m_h, exp_retired());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 4'h0, 2'd0, 8'h00, 8'h00);
    for (int n = 1; n <= 65540; n++) begin
      tick();
      if (n == 65534 || n == 65535 || n == 65540) begin
        checks++;
        if (retired !== exp_retired()) begin
          errors++;
          $display("FAIL sat_count[%0d] got %h exp %h", n, retired, exp_retired());
        end
      end
    end
    idle();
    checks++;
    if (retired !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final got %h exp ffff", retired);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    rd_addr_a   = 2'd0;
    rd_addr_b   = 2'd0;
    wb_valid    = 1'b0;
    wb_op       = 4'h0;
    wb_ra       = 2'd0;
    wb_alu_data = 8'h00;
    wb_mem_data = 8'h00;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_z   = 1'b0;
    m_h   = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_alu_write();
    test_load_store();
    test_bubble();
    test_halt();
    test_reset_override();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
